can_bit_timing: RTL
===================

# can_bit_timing

CAN bit-timing controller: sequences the system clock into time quanta (TQ) and CAN bit segments, and issues the sample-point and bit-start strobes used by the CAN bit stream processor. It sits between the clocking logic and the Tx/Rx bit engines of the CAN classic controller. It performs hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant edges of the received bus line.

## Interface
- BRP_W, 6: prescaler field width; TQ = (brp+1) clk periods
- TSEG1_W, 4: TSEG1 field width; TSEG1 = tseg1+1 TQ (PROP+PHASE1)
- TSEG2_W, 3: TSEG2 field width; TSEG2 = tseg2+1 TQ (PHASE2)
- SJW_W, 2: SJW field width; SJW = sjw+1 TQ
- clk  in  1  system clock, single clock domain
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = run bit timing; 0 = idle, config latched
- brp  in  BRP_W  prescaler setting
- tseg1  in  TSEG1_W  TSEG1 setting
- tseg2  in  TSEG2_W  TSEG2 setting; must be ≥ sjw
- sjw  in  SJW_W  resync jump width setting
- rx  in  1  bus Rx, already 2-FF synchronised to clk (0 = dominant)
- hard_sync_en  in  1  1 = next recessive→dominant edge causes hard sync (bus idle / SOF)
- tq_tick  out  1  one-clk pulse at the end of each TQ
- bit_start  out  1  one-clk pulse when SYNC_SEG begins
- sample_pt  out  1  one-clk pulse at the sample point
- rx_bit  out  1  rx value captured at the last sample point
- seg  out  2  current segment: 0 IDLE, 1 SYNC, 2 TSEG1, 3 TSEG2

## Operation
- States: IDLE, SYNC, TSEG1, TSEG2. The state register drives `seg` directly.
- IDLE: enter on reset or whenever enable=0. brp/tseg1/tseg2/sjw are latched every clk while in IDLE and held constant otherwise.
- IDLE exit: enable=1 → SYNC on the next clk, with prescaler and segment counters cleared.
- Prescaler: counts 0..brp; tq_tick when count==brp, then wraps to 0. With brp=0, tq_tick is asserted every clk.
- Segment progression, evaluated on tq_tick only:
  - SYNC lasts 1 TQ → TSEG1.
  - TSEG1 lasts tseg1+1+ext TQ → TSEG2.
  - TSEG2 lasts tseg2+1−shr TQ → SYNC.
- Edge detect: rx_q is updated every tq_tick. An edge is rx_q=1 and rx=0 at a tq_tick.
- Hard sync: an edge with hard_sync_en=1 in any non-IDLE state forces SYNC immediately. The TQ containing the edge counts as SYNC_SEG, and bit_start pulses. ext and shr are cleared.
- Resync: an edge with hard_sync_en=0, at most once per bit. The allowance is rearmed at sample_pt.
  - In SYNC: phase error 0, no action.
  - In TSEG1 at index k (0-based): ext = min(k+1, sjw+1).
  - In TSEG2 at index k: remaining r = tseg2−k. shr = min(r, sjw+1), clipped so that TSEG2 never ends before the current TQ. If r ≤ sjw+1, the next TQ is SYNC.
- Sample point: on the tq_tick that ends TSEG1. sample_pt pulses and rx_bit ← rx on the same clk.
- ext is applied only while still in TSEG1. shr is applied only in the current TSEG2.

## Timing
- All outputs are registered.
- Reset values: tq_tick=0, bit_start=0, sample_pt=0, rx_bit=1, seg=0; all counters and ext/shr = 0.
- Nominal bit = (3+tseg1+tseg2)·(brp+1) clk.
- bit_start pulses in the clk following the tq_tick that enters SYNC. The first bit_start after enable rises comes 1 clk after the IDLE→SYNC transition.
- enable dropping mid-bit: IDLE on the next clk. No further strobes are issued and any pending resync is discarded.
- Async reset mid-bit: all state clears immediately. Operation restarts from IDLE after rst_n deasserts, synchronous to clk.
- Hard sync and resync edge on the same tick: hard sync wins.

## Structure
- Shared package can_pkg holds the segment encoding constants (SEG_IDLE/SYNC/TSEG1/TSEG2) and the default field widths. These are reused by the bit stream processor.
- One sub-module, can_tq_prescaler: the brp counter and tq_tick generation. It has a synchronous clear used for IDLE exit and hard sync.
- The segment FSM, edge detect and SJW arithmetic live in the top level. Phase-error arithmetic uses TSEG1_W+1 bits so there is no overflow.

## Test plan
- Nominal timing: brp=4, tseg1=5, tseg2=2, rx held 1 → tq_tick every 5 clk; bit_start every 50 clk; sample_pt 35 clk after each bit_start.
- Hard sync: hard_sync_en=1, rx falls at TSEG1 index 3 → bit_start on the next TQ boundary; the following sample_pt is 7 TQ later.
- Late edge: sjw=1, hard_sync_en=0, edge at TSEG1 index 2 → that bit is 12 TQ long and its sample point is delayed 2 TQ.
- Early edge: sjw=1, edge at TSEG2 index 0 (r=2) → TSEG2 shortened to 1 TQ and SYNC follows; bit is 8 TQ.
- Single resync per bit: two edges in one bit → only the first adjusts timing.
- Disable/reset mid-bit: enable=0 at TSEG2, or rst_n pulse → seg=0 with no strobes. A new brp=0 latched in IDLE gives a tq_tick every clk after re-enable.

Source files
------------

// File: rtl/can_pkg.sv
// CAN shared definitions: segment encoding
// and default bit-timing field widths.
package can_pkg;

  localparam logic [1:0] SEG_IDLE  = 2'd0;
  localparam logic [1:0] SEG_SYNC  = 2'd1;
  localparam logic [1:0] SEG_TSEG1 = 2'd2;
  localparam logic [1:0] SEG_TSEG2 = 2'd3;

  localparam int BRP_W_DEF   = 6;
  localparam int TSEG1_W_DEF = 4;
  localparam int TSEG2_W_DEF = 3;
  localparam int SJW_W_DEF   = 2;

  typedef enum logic [1:0] {
    S_IDLE  = SEG_IDLE,
    S_SYNC  = SEG_SYNC,
    S_TSEG1 = SEG_TSEG1,
    S_TSEG2 = SEG_TSEG2
  } seg_e;

endpackage

// File: rtl/can_bit_timing_if.sv
// Bit-timing bundle: configuration and rx in,
// TQ / bit strobes and segment state out.
interface can_bit_timing_if
  import can_pkg::*;
#(
  parameter int BRP_W   = BRP_W_DEF,
  parameter int TSEG1_W = TSEG1_W_DEF,
  parameter int TSEG2_W = TSEG2_W_DEF,
  parameter int SJW_W   = SJW_W_DEF
);

  logic               enable;
  logic [BRP_W-1:0]   brp;
  logic [TSEG1_W-1:0] tseg1;
  logic [TSEG2_W-1:0] tseg2;
  logic [SJW_W-1:0]   sjw;
  logic               rx;
  logic               hard_sync_en;
  logic               tq_tick;
  logic               bit_start;
  logic               sample_pt;
  logic               rx_bit;
  logic [1:0]         seg;

  modport master (
    output enable, brp, tseg1, tseg2, sjw,
    output rx, hard_sync_en,
    input  tq_tick, bit_start, sample_pt,
    input  rx_bit, seg
  );

  modport slave (
    input  enable, brp, tseg1, tseg2, sjw,
    input  rx, hard_sync_en,
    output tq_tick, bit_start, sample_pt,
    output rx_bit, seg
  );

endinterface

// File: rtl/can_tq_prescaler.sv
// Time-quantum prescaler: divides clk by
// brp+1 and flags the last clk of each TQ.
module can_tq_prescaler #(
  parameter int BRP_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr,
  input  logic [BRP_W-1:0] brp,
  output logic             tick,
  output logic             tq_tick
);

  logic [BRP_W-1:0] cnt;

  assign tick = run && (cnt == brp);

  // count 0..brp while running, registered tq_tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      tq_tick <= 1'b0;
    end else begin
      tq_tick <= tick;
      if (clr || !run || tick)
        cnt <= '0;
      else
        cnt <= cnt + BRP_W'(1);
    end
  end

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit-timing controller: segment FSM,
// hard sync and SJW-limited resync.
module can_bit_timing
  import can_pkg::*;
#(
  parameter int BRP_W   = BRP_W_DEF,
  parameter int TSEG1_W = TSEG1_W_DEF,
  parameter int TSEG2_W = TSEG2_W_DEF,
  parameter int SJW_W   = SJW_W_DEF
) (
  input logic        clk,
  input logic        rst_n,
  can_bit_timing_if.slave bus
);

  localparam int W = TSEG1_W + 1;

  seg_e state, nxt;

  logic [BRP_W-1:0]   brp_l;
  logic [TSEG1_W-1:0] tseg1_l;
  logic [TSEG2_W-1:0] tseg2_l;
  logic [SJW_W-1:0]   sjw_l;

  logic [W-1:0] scnt, scnt_n;
  logic [W-1:0] ext, ext_n;
  logic [W-1:0] shr, shr_n;
  logic         done, done_n;
  logic         rx_q;

  logic tick, run, clr;
  logic enter_sync, smp;
  logic fall, hard, rs;

  logic [W-1:0] sjw1, k1, rem;
  logic [W-1:0] ext_new, shr_new;
  logic [W-1:0] ext_eff, shr_eff;

  assign run  = bus.enable && (state != S_IDLE);
  assign fall = tick && rx_q && !bus.rx;
  assign hard = fall && bus.hard_sync_en;
  assign rs   = fall && !bus.hard_sync_en
             && !done
             && (state == S_TSEG1 ||
                 state == S_TSEG2);

  assign sjw1 = W'(sjw_l) + W'(1);
  assign k1   = scnt + W'(1);
  assign rem  = W'(tseg2_l) - scnt;

  assign ext_new = (k1 < sjw1) ? k1 : sjw1;
  assign shr_new = (rem < sjw1) ? rem : sjw1;
  assign ext_eff = rs ? ext_new : ext;
  assign shr_eff = rs ? shr_new : shr;

  assign bus.seg = state;

  can_tq_prescaler #(
    .BRP_W (BRP_W)
  ) u_pre (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (run),
    .clr     (clr),
    .brp     (brp_l),
    .tick    (tick),
    .tq_tick (bus.tq_tick)
  );

  // next segment, counters and phase corrections
  always_comb begin
    nxt        = state;
    scnt_n     = scnt;
    ext_n      = ext;
    shr_n      = shr;
    done_n     = done;
    clr        = 1'b0;
    enter_sync = 1'b0;
    smp        = 1'b0;
    if (!bus.enable) begin
      nxt    = S_IDLE;
      scnt_n = '0;
      ext_n  = '0;
      shr_n  = '0;
      done_n = 1'b0;
    end else if (state == S_IDLE) begin
      nxt        = S_SYNC;
      scnt_n     = '0;
      clr        = 1'b1;
      enter_sync = 1'b1;
    end else if (hard) begin
      nxt        = S_SYNC;
      scnt_n     = '0;
      ext_n      = '0;
      shr_n      = '0;
      clr        = 1'b1;
      enter_sync = 1'b1;
    end else if (tick) begin
      if (rs)
        done_n = 1'b1;
      unique case (1'b1)
        state == S_SYNC: begin
          nxt    = S_TSEG1;
          scnt_n = '0;
        end
        state == S_TSEG1: begin
          if (scnt >= W'(tseg1_l) + ext_eff) begin
            nxt    = S_TSEG2;
            scnt_n = '0;
            ext_n  = '0;
            smp    = 1'b1;
            done_n = 1'b0;
          end else begin
            scnt_n = k1;
            ext_n  = ext_eff;
          end
        end
        state == S_TSEG2: begin
          if (scnt + shr_eff >= W'(tseg2_l)) begin
            nxt        = S_SYNC;
            scnt_n     = '0;
            shr_n      = '0;
            enter_sync = 1'b1;
          end else begin
            scnt_n = k1;
            shr_n  = shr_eff;
          end
        end
        default: ;
      endcase
    end
  end

  // FSM state, counters, rx history, config
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      scnt    <= '0;
      ext     <= '0;
      shr     <= '0;
      done    <= 1'b0;
      rx_q    <= 1'b1;
      brp_l   <= '0;
      tseg1_l <= '0;
      tseg2_l <= '0;
      sjw_l   <= '0;
    end else begin
      state <= nxt;
      scnt  <= scnt_n;
      ext   <= ext_n;
      shr   <= shr_n;
      done  <= done_n;
      if (tick)
        rx_q <= bus.rx;
      if (state == S_IDLE) begin
        brp_l   <= bus.brp;
        tseg1_l <= bus.tseg1;
        tseg2_l <= bus.tseg2;
        sjw_l   <= bus.sjw;
      end
    end
  end

  // registered bit and sample strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bit_start <= 1'b0;
      bus.sample_pt <= 1'b0;
      bus.rx_bit    <= 1'b1;
    end else begin
      bus.bit_start <= enter_sync;
      bus.sample_pt <= smp;
      if (smp)
        bus.rx_bit <= bus.rx;
    end
  end

endmodule
